// File: rtl/adc_uart_sched.sv
// Burst scheduler: paces ADC triggers and counts samples into an external FIFO,
// then drains the FIFO to a byte UART big-endian. Define ADC_SCHED_HEADER_EN for an A5/5A preamble.
module adc_uart_sched #(
  parameter int SAMPLE_DIV = 100,
  parameter int BURST_LEN  = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        overflow_o,
  output logic        adc_trig_o,
  input  logic        adc_valid_i,
  output logic        fifo_wr_en_o,
  input  logic        fifo_full_i,
  input  logic        fifo_empty_i,
  output logic        fifo_rd_en_o,
  input  logic [15:0] fifo_dout_i,
  output logic [7:0]  uart_tx_data_o,
  output logic        uart_tx_valid_o,
  input  logic        uart_tx_ready_i
);

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [10:0] CNT_LAST = 11'(BURST_LEN - 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    CAPTURE    = 4'd1,
    DRAIN_RD   = 4'd2,
    DRAIN_WAIT = 4'd3,
    SEND_HI    = 4'd4,
    SEND_LO    = 4'd5,
    DONE       = 4'd6
`ifdef ADC_SCHED_HEADER_EN
    ,
    HDR0       = 4'd7,
    HDR1       = 4'd8
`endif
  } state_t;

`ifdef ADC_SCHED_HEADER_EN
  localparam state_t AFTER_CAPTURE = HDR0;
`else
  localparam state_t AFTER_CAPTURE = DRAIN_RD;
`endif

  state_t      state_reg, state_next;
  logic [15:0] div_reg, div_next;
  logic [10:0] cnt_reg, cnt_next;
  logic [15:0] hold_reg, hold_next;
  logic        overflow_reg, overflow_next;

  logic        trig_c, wr_en_c, rd_en_c, tx_valid_c, done_c;
  logic [7:0]  tx_data_c;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      cnt_reg      <= '0;
      hold_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      cnt_reg      <= cnt_next;
      hold_reg     <= hold_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    cnt_next      = cnt_reg;
    hold_next     = hold_reg;
    overflow_next = overflow_reg;
    trig_c        = 1'b0;
    wr_en_c       = 1'b0;
    rd_en_c       = 1'b0;
    tx_valid_c    = 1'b0;
    tx_data_c     = 8'h00;
    done_c        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          state_next    = CAPTURE;
          div_next      = '0;
          cnt_next      = '0;
          overflow_next = 1'b0;
        end
      end

      CAPTURE: begin
        trig_c   = (div_reg == 16'd0);
        div_next = (div_reg == DIV_LAST) ? 16'd0 : div_reg + 16'd1;
        // A sample arriving while the FIFO is full is dropped and not counted.
        if (adc_valid_i) begin
          if (fifo_full_i) begin
            overflow_next = 1'b1;
          end else begin
            wr_en_c  = 1'b1;
            cnt_next = cnt_reg + 11'd1;
            if (cnt_reg == CNT_LAST) begin
              state_next = AFTER_CAPTURE;
            end
          end
        end
      end

`ifdef ADC_SCHED_HEADER_EN
      HDR0: begin
        tx_valid_c = 1'b1;
        tx_data_c  = 8'hA5;
        if (uart_tx_ready_i) state_next = HDR1;
      end

      HDR1: begin
        tx_valid_c = 1'b1;
        tx_data_c  = 8'h5A;
        if (uart_tx_ready_i) state_next = DRAIN_RD;
      end
`endif

      DRAIN_RD: begin
        if (fifo_empty_i) begin
          state_next = DONE;
        end else begin
          rd_en_c    = 1'b1;
          state_next = DRAIN_WAIT;
        end
      end

      // Standard FIFO: read data appears one cycle after the strobe.
      DRAIN_WAIT: begin
        hold_next  = fifo_dout_i;
        state_next = SEND_HI;
      end

      SEND_HI: begin
        tx_valid_c = 1'b1;
        tx_data_c  = hold_reg[15:8];
        if (uart_tx_ready_i) state_next = SEND_LO;
      end

      SEND_LO: begin
        tx_valid_c = 1'b1;
        tx_data_c  = hold_reg[7:0];
        if (uart_tx_ready_i) state_next = DRAIN_RD;
      end

      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy_o          = (state_reg != IDLE);
  assign done_o          = done_c;
  assign overflow_o      = overflow_reg;
  assign adc_trig_o      = trig_c;
  assign fifo_wr_en_o    = wr_en_c;
  assign fifo_rd_en_o    = rd_en_c;
  assign uart_tx_valid_o = tx_valid_c;
  assign uart_tx_data_o  = tx_data_c;

endmodule

// File: tb/tb_adc_uart_sched.sv
// Scoreboard bench for adc_uart_sched: stimulus pushes expected UART bytes, trigger
// offsets and done offsets; a forked monitor consumes them as the DUT produces events.
module tb_adc_uart_sched;

  localparam int SAMPLE_DIV = 4;
  localparam int BURST_LEN  = 3;
`ifdef ADC_SCHED_HEADER_EN
  localparam int HDR_CYC = 2;
  localparam int HDR_N   = 2;
`else
  localparam int HDR_CYC = 0;
  localparam int HDR_N   = 0;
`endif

  logic        sys_clk;
  logic        sys_rst;
  logic        start_i;
  logic        busy_o, done_o, overflow_o, adc_trig_o;
  logic        adc_valid_i, fifo_wr_en_o, fifo_full_i, fifo_empty_i, fifo_rd_en_o;
  logic [15:0] fifo_dout_i;
  logic [7:0]  uart_tx_data_o;
  logic        uart_tx_valid_o, uart_tx_ready_i;

  adc_uart_sched #(.SAMPLE_DIV(SAMPLE_DIV), .BURST_LEN(BURST_LEN)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o),
    .adc_trig_o(adc_trig_o), .adc_valid_i(adc_valid_i),
    .fifo_wr_en_o(fifo_wr_en_o), .fifo_full_i(fifo_full_i),
    .fifo_empty_i(fifo_empty_i), .fifo_rd_en_o(fifo_rd_en_o),
    .fifo_dout_i(fifo_dout_i), .uart_tx_data_o(uart_tx_data_o),
    .uart_tx_valid_o(uart_tx_valid_o), .uart_tx_ready_i(uart_tx_ready_i)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ADC + FIFO environment model
  int          cyc = 0;
  int          start_cyc = 0;
  int          adc_idx = 0;
  int          wr_cnt = 0;
  logic [15:0] samples [0:7];
  logic        full_mask [0:7];
  logic        model_valid = 1'b0, model_full = 1'b0;
  logic        manual_valid, manual_full;
  logic [15:0] adc_data = 16'h0;
  logic [15:0] fifo_q [$];
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_dout = 16'h0;

  assign adc_valid_i  = model_valid | manual_valid;
  assign fifo_full_i  = model_full | manual_full;
  assign fifo_empty_i = fifo_empty;
  assign fifo_dout_i  = fifo_dout;

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (sys_rst) begin
      fifo_q.delete();
      fifo_empty  <= 1'b1;
      fifo_dout   <= 16'h0;
      model_valid <= 1'b0;
      model_full  <= 1'b0;
      adc_idx     <= 0;
      wr_cnt      <= 0;
    end else begin
      model_valid <= adc_trig_o;
      model_full  <= adc_trig_o && (adc_idx < 8) && full_mask[adc_idx & 7];
      if (adc_trig_o) begin
        adc_data <= samples[adc_idx & 7];
        adc_idx  <= adc_idx + 1;
      end
      if (fifo_wr_en_o) begin
        fifo_q.push_back(adc_data);
        wr_cnt <= wr_cnt + 1;
      end
      if (fifo_rd_en_o && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
      if (start_i && !busy_o) begin
        start_cyc <= cyc + 1;
        adc_idx   <= 0;
        wr_cnt    <= 0;
      end
    end
  end

  // Scoreboard
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_byte [$];
  int         exp_trig [$];
  int         exp_done [$];
  int         byte_rd = 0, trig_rd = 0, done_rd = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("valid_held", 32'(uart_tx_valid_o), 32'd1);
          check("data_held", 32'(uart_tx_data_o), 32'(prev_data));
        end
        if (uart_tx_valid_o && uart_tx_ready_i) begin
          if (byte_rd < exp_byte.size()) check("uart_byte", 32'(uart_tx_data_o), 32'(exp_byte[byte_rd]));
          else check("uart_byte_count", byte_rd + 1, exp_byte.size());
          $display("[TB] uart byte %02h", uart_tx_data_o);
          byte_rd++;
        end
        stall_prev = uart_tx_valid_o && !uart_tx_ready_i;
        prev_data  = uart_tx_data_o;
        if (adc_trig_o) begin
          if (trig_rd < exp_trig.size()) check("trig_offset", cyc - start_cyc, exp_trig[trig_rd]);
          else check("trig_count", trig_rd + 1, exp_trig.size());
          trig_rd++;
        end
        if (done_o) begin
          if (done_rd < exp_done.size()) check("done_offset", cyc - start_cyc, exp_done[done_rd]);
          else check("done_count", done_rd + 1, exp_done.size());
          $display("[TB] done at offset %0d", cyc - start_cyc);
          done_rd++;
        end
      end
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    exp_byte.push_back(w[15:8]);
    exp_byte.push_back(w[7:0]);
  endtask

  task automatic push_hdr();
`ifdef ADC_SCHED_HEADER_EN
    exp_byte.push_back(8'hA5);
    exp_byte.push_back(8'h5A);
`endif
  endtask

  task automatic start_burst();
    @(posedge sys_clk); #1 start_i = 1'b1;
    @(posedge sys_clk); #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    logic got;
    got = 1'b0;
    for (int k = 0; k < limit && !got; k++) begin
      @(negedge sys_clk);
      if (done_o) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
  endtask

  task automatic check_drained(input int exp_wr);
    check("wr_count", wr_cnt, exp_wr);
    @(negedge sys_clk);
    check("busy_after_done", 32'(busy_o), 32'd0);
    check("bytes_consumed", byte_rd, exp_byte.size());
    check("trigs_consumed", trig_rd, exp_trig.size());
    check("dones_consumed", done_rd, exp_done.size());
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_trig", 32'(adc_trig_o), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en_o), 32'd0);
    check("rst_tx_valid", 32'(uart_tx_valid_o), 32'd0);
    check("rst_tx_data", 32'(uart_tx_data_o), 32'd0);
  endtask

  task automatic load3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    samples[0] = a; samples[1] = b; samples[2] = c;
  endtask

  initial begin
    logic [7:0] first_byte;
    int         hs;
    logic       seen;
    sys_rst = 1'b1; start_i = 1'b0; uart_tx_ready_i = 1'b1;
    manual_valid = 1'b0; manual_full = 1'b0;
    for (int i = 0; i < 8; i++) begin samples[i] = 16'h0; full_mask[i] = 1'b0; end
    fork monitor(); join_none

    repeat (3) @(negedge sys_clk);
    check_reset_outputs();
    @(posedge sys_clk); #1 sys_rst = 1'b0;

    // adc_valid_i in IDLE, with and without full: ignored
    @(posedge sys_clk); #1 manual_valid = 1'b1;
    @(negedge sys_clk); check("idle_wr_en", 32'(fifo_wr_en_o), 32'd0);
    @(posedge sys_clk); #1 manual_full = 1'b1;
    @(negedge sys_clk); check("idle_wr_en_full", 32'(fifo_wr_en_o), 32'd0);
    @(posedge sys_clk); #1 manual_valid = 1'b0; manual_full = 1'b0;
    @(negedge sys_clk); check("idle_overflow", 32'(overflow_o), 32'd0);

    // Normal burst, ready always high
    load3(16'h1234, 16'hABCD, 16'h5678);
    exp_trig.push_back(0); exp_trig.push_back(4); exp_trig.push_back(8);
    push_hdr(); push_word(16'h1234); push_word(16'hABCD); push_word(16'h5678);
    exp_done.push_back(23 + HDR_CYC);
    start_burst();
    wait_done(200);
    check_drained(3);

    // Ready held low for five cycles on the first offered byte
`ifdef ADC_SCHED_HEADER_EN
    first_byte = 8'hA5;
`else
    first_byte = 8'h12;
`endif
    load3(16'h1234, 16'h0F0F, 16'hBEEF);
    exp_trig.push_back(0); exp_trig.push_back(4); exp_trig.push_back(8);
    push_hdr(); push_word(16'h1234); push_word(16'h0F0F); push_word(16'hBEEF);
    exp_done.push_back(28 + HDR_CYC);
    uart_tx_ready_i = 1'b0;
    start_burst();
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge sys_clk);
      if (uart_tx_valid_o) seen = 1'b1;
    end
    check("stall_valid_seen", 32'(seen), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge sys_clk);
      check("stall_valid", 32'(uart_tx_valid_o), 32'd1);
      check("stall_data", 32'(uart_tx_data_o), 32'(first_byte));
    end
    @(posedge sys_clk); #1 uart_tx_ready_i = 1'b1;
    wait_done(200);
    check_drained(3);

    // Second sample hits a full FIFO: dropped, overflow set, burst extends
    samples[0] = 16'h1111; samples[1] = 16'h2222; samples[2] = 16'h3333; samples[3] = 16'h4444;
    full_mask[1] = 1'b1;
    exp_trig.push_back(0); exp_trig.push_back(4); exp_trig.push_back(8); exp_trig.push_back(12);
    push_hdr(); push_word(16'h1111); push_word(16'h3333); push_word(16'h4444);
    exp_done.push_back(27 + HDR_CYC);
    start_burst();
    wait_done(200);
    check("overflow_set", 32'(overflow_o), 32'd1);
    check_drained(3);
    full_mask[1] = 1'b0;

    // Next start clears overflow; reset lands in SEND_LO of the first word
    load3(16'h1234, 16'hABCD, 16'h5678);
    exp_trig.push_back(0); exp_trig.push_back(4); exp_trig.push_back(8);
    push_hdr(); exp_byte.push_back(8'h12);
    start_burst();
    @(negedge sys_clk); check("overflow_cleared", 32'(overflow_o), 32'd0);
    hs = 0;
    for (int k = 0; k < 200 && hs < HDR_N + 1; k++) begin
      @(negedge sys_clk);
      if (uart_tx_valid_o && uart_tx_ready_i) hs++;
    end
    check("hi_handshake_seen", hs, HDR_N + 1);
    @(posedge sys_clk); #1 uart_tx_ready_i = 1'b0; sys_rst = 1'b1;
    @(negedge sys_clk);
    check("lo_valid", 32'(uart_tx_valid_o), 32'd1);
    check("lo_data", 32'(uart_tx_data_o), 32'h34);
    @(negedge sys_clk);
    check_reset_outputs();
    @(posedge sys_clk); #1 sys_rst = 1'b0; uart_tx_ready_i = 1'b1;
    @(posedge sys_clk);

    // Fresh burst after the mid-burst reset
    load3(16'h00FF, 16'h8001, 16'h7E55);
    exp_trig.push_back(0); exp_trig.push_back(4); exp_trig.push_back(8);
    push_hdr(); push_word(16'h00FF); push_word(16'h8001); push_word(16'h7E55);
    exp_done.push_back(23 + HDR_CYC);
    start_burst();
    wait_done(200);
    check_drained(3);

    repeat (2) @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
